// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - request/response bundle for the pipelined mux tree
// Signals (direction as seen from the slave, i.e. the mux tree):
//   din       in   NUM_IN*DWIDTH flattened channels, channel k = din[k*DWIDTH +: DWIDTH]
//   mode      in   0 = direct, 1 = scan
//   in_valid  in   direct request valid
//   in_ready  out  direct request accepted when in_valid & in_ready
//   sel       in   channel index of a direct request
//   start     in   scan start pulse
//   busy      out  scan in progress
//   done      out  one-cycle end-of-scan pulse
//   out_valid out  dout/out_ch valid
//   out_ready in   downstream accept
//   dout      out  selected channel data
//   out_ch    out  channel index of dout
interface mux_tree_pipe_if #(
    parameter int DWIDTH = 16,
    parameter int LEVELS = 2
);
    localparam int NUM_IN = 4 ** LEVELS;
    localparam int SEL_W  = 2 * LEVELS;

    logic [NUM_IN*DWIDTH-1:0] din;
    logic                     mode;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         sel;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     out_valid;
    logic                     out_ready;
    logic [DWIDTH-1:0]        dout;
    logic [SEL_W-1:0]         out_ch;

    modport master (
        output din, mode, in_valid, sel, start, out_ready,
        input  in_ready, busy, done, out_valid, dout, out_ch
    );

    modport slave (
        input  din, mode, in_valid, sel, start, out_ready,
        output in_ready, busy, done, out_valid, dout, out_ch
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined NUM_IN:1 selector built from registered 4:1 stages
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    mux_tree_pipe_if.slave (din, mode, in_valid/in_ready, sel, start, busy, done,
//          out_valid/out_ready, dout, out_ch)
module mux_tree_pipe #(
    parameter int DWIDTH = 16,
    parameter int LEVELS = 2,
    parameter int NUM_IN = 4 ** LEVELS,
    parameter int SEL_W  = 2 * LEVELS
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_tree_pipe_if.slave bus
);
    // Every stage register is sized for the widest (first) stage; later stages use
    // only their low NUM_IN/4**(s+1) words and keep the rest at zero.
    localparam int STG_W = (NUM_IN / 4) * DWIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_count;
    logic              r_busy;
    logic              r_done;
    logic [LEVELS-1:0] r_vld;
    logic [SEL_W-1:0]  r_idx  [LEVELS];
    logic [STG_W-1:0]  r_data [LEVELS];

    logic [STG_W-1:0]  w_next [LEVELS];
    logic [LEVELS-1:0] w_en;
    logic              w_out_valid;
    logic              w_stall;
    logic              w_idle;
    logic              w_in_ready;
    logic              w_start_ok;
    logic              w_issue;
    logic              w_last_acc;
    logic [SEL_W-1:0]  w_issue_idx;
    logic              w_unused_bits;

    assign w_out_valid = r_vld[LEVELS-1];
    assign w_stall     = w_out_valid & ~bus.out_ready;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_in_ready  = rst_n & w_idle & ~bus.mode & ~w_stall;
    // A start coinciding with the done pulse is dropped so a scan cannot chain blindly.
    assign w_start_ok  = w_idle & bus.start & bus.mode & ~w_stall & ~r_done;
    assign w_issue_idx = (r_state == ST_SCAN) ? r_count : bus.sel;
    assign w_issue     = (bus.in_valid & w_in_ready) | ((r_state == ST_SCAN) & ~w_stall);
    assign w_last_acc  = (r_state == ST_DRAIN) & w_out_valid & bus.out_ready
                         & (r_idx[LEVELS-1] == LAST_CH);

    // A stage may load when it is empty or the stage after it moves; this lets
    // bubbles collapse while a full output stage is held by backpressure.
    always_comb begin
        w_en = '0;
        w_en[LEVELS-1] = ~r_vld[LEVELS-1] | bus.out_ready;
        for (int s = LEVELS - 2; s >= 0; s--) begin
            w_en[s] = ~r_vld[s] | w_en[s+1];
        end
    end

    // Level s+1 muxes use index bits [2s+1:2s]; stage 0 picks straight from din.
    always_comb begin
        for (int s = 0; s < LEVELS; s++) begin
            w_next[s] = '0;
        end
        for (int k = 0; k < NUM_IN / 4; k++) begin
            w_next[0][k*DWIDTH +: DWIDTH] =
                bus.din[(4*k + int'(w_issue_idx[1:0]))*DWIDTH +: DWIDTH];
        end
        for (int s = 1; s < LEVELS; s++) begin
            for (int k = 0; k < NUM_IN / 4; k++) begin
                if (k < (NUM_IN >> (2*(s+1)))) begin
                    w_next[s][k*DWIDTH +: DWIDTH] =
                        r_data[s-1][(4*k + int'(r_idx[s-1][2*s +: 2]))*DWIDTH +: DWIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vld   <= '0;
            for (int s = 0; s < LEVELS; s++) begin
                r_idx[s]  <= '0;
                r_data[s] <= '0;
            end
        end else begin
            if (w_en[0]) begin
                r_vld[0]  <= w_issue;
                r_idx[0]  <= w_issue_idx;
                r_data[0] <= w_next[0];
            end
            for (int s = 1; s < LEVELS; s++) begin
                if (w_en[s]) begin
                    r_vld[s]  <= r_vld[s-1];
                    r_idx[s]  <= r_idx[s-1];
                    r_data[s] <= w_next[s];
                end
            end

            r_done <= w_last_acc;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_SCAN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!w_stall) begin
                        r_count <= r_count + SEL_W'(1);
                        if (r_count == LAST_CH) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_acc) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_unused_bits = ^r_data[LEVELS-1];

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = w_out_valid;
    assign bus.dout      = r_data[LEVELS-1][DWIDTH-1:0];
    assign bus.out_ch    = r_idx[LEVELS-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - directed and random bench for mux_tree_pipe at LEVELS 1, 2 and 3
module tb_mux_tree_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       in_valid;
    logic       start;
    logic       out_ready;
    logic [5:0] sel;
    logic [3:0] salt;
    bit         full_speed;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lv
        localparam int L  = g + 1;
        localparam int N  = 4 ** L;
        localparam int SW = 2 * L;

        mux_tree_pipe_if #(.DWIDTH(16), .LEVELS(L)) u_if ();

        mux_tree_pipe #(.DWIDTH(16), .LEVELS(L)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );

        assign u_if.mode      = mode;
        assign u_if.in_valid  = in_valid;
        assign u_if.sel       = sel[SW-1:0];
        assign u_if.start     = start;
        assign u_if.out_ready = out_ready;

        always_comb begin
            u_if.din = '0;
            for (int k = 0; k < N; k++) begin
                u_if.din[k*16 +: 16] = {salt, 12'h000} + 16'(k);
            end
        end

        // Reference: a queue of beats the design owes, in delivery order.
        int              q_ch[$];
        logic [15:0]     q_dat[$];
        bit              q_last[$];
        bit              scanning;
        bit              exp_done;
        bit              rst_edge;
        bit              prev_stall;
        logic [15:0]     prev_dout;
        logic [SW-1:0]   prev_ch;
        int              busy_cnt;
        int              pend;

        always @(posedge clk) rst_edge <= ~rst_n;

        always @(negedge clk) begin : mon
            bit stall;
            bit scan_now;
            bit done_now;
            int ch;
            if (rst_edge) begin
                chk($sformatf("L%0d rst out_valid", L), 32'(u_if.out_valid), 32'd0);
                chk($sformatf("L%0d rst dout", L), 32'(u_if.dout), 32'd0);
                chk($sformatf("L%0d rst out_ch", L), 32'(u_if.out_ch), 32'd0);
                q_ch.delete();
                q_dat.delete();
                q_last.delete();
                scanning   = 1'b0;
                exp_done   = 1'b0;
                busy_cnt   = 0;
                prev_stall = 1'b0;
            end
            stall    = u_if.out_valid & ~out_ready;
            scan_now = scanning;
            done_now = exp_done;
            exp_done = 1'b0;
            chk($sformatf("L%0d done", L), 32'(u_if.done), 32'(done_now));
            chk($sformatf("L%0d busy", L), 32'(u_if.busy), 32'(scan_now));
            chk($sformatf("L%0d in_ready", L), 32'(u_if.in_ready),
                32'(rst_n & ~scan_now & ~mode & ~stall));
            if (prev_stall) begin
                chk($sformatf("L%0d hold valid", L), 32'(u_if.out_valid), 32'd1);
                chk($sformatf("L%0d hold dout", L), 32'(u_if.dout), 32'(prev_dout));
                chk($sformatf("L%0d hold ch", L), 32'(u_if.out_ch), 32'(prev_ch));
            end
            prev_stall = stall;
            prev_dout  = u_if.dout;
            prev_ch    = u_if.out_ch;
            if (u_if.out_valid && out_ready) begin
                chk($sformatf("L%0d beat expected", L), 32'(q_ch.size() != 0), 32'd1);
                if (q_ch.size() != 0) begin
                    chk($sformatf("L%0d beat ch", L), 32'(u_if.out_ch), 32'(q_ch[0]));
                    chk($sformatf("L%0d beat data", L), 32'(u_if.dout), 32'(q_dat[0]));
                    if (q_last[0]) begin
                        scanning = 1'b0;
                        exp_done = 1'b1;
                    end
                    void'(q_ch.pop_front());
                    void'(q_dat.pop_front());
                    void'(q_last.pop_front());
                end
            end
            if (u_if.busy) begin
                busy_cnt++;
            end else begin
                if (busy_cnt > 0 && full_speed) begin
                    chk($sformatf("L%0d busy length", L), 32'(busy_cnt), 32'(N + L));
                end
                busy_cnt = 0;
            end
            if (rst_n) begin
                if (!scan_now && !mode && !stall && in_valid) begin
                    ch = int'(sel) % N;
                    q_ch.push_back(ch);
                    q_dat.push_back({salt, 12'h000} + 16'(ch));
                    q_last.push_back(1'b0);
                end
                if (!scan_now && mode && start && !stall && !done_now) begin
                    for (int k = 0; k < N; k++) begin
                        q_ch.push_back(k);
                        q_dat.push_back({salt, 12'h000} + 16'(k));
                        q_last.push_back(k == N - 1);
                    end
                    scanning = 1'b1;
                end
            end
            pend = q_ch.size() + int'(scanning);
        end
    end

    wire        l2_ov   = g_lv[1].u_if.out_valid;
    wire [15:0] l2_dout = g_lv[1].u_if.dout;
    wire [3:0]  l2_ch   = g_lv[1].u_if.out_ch;
    wire        l2_ir   = g_lv[1].u_if.in_ready;
    wire        l2_busy = g_lv[1].u_if.busy;
    wire        l2_done = g_lv[1].u_if.done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        while ((g_lv[0].pend + g_lv[1].pend + g_lv[2].pend) != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain within budget", 32'(n < 500), 32'd1);
        repeat (4) tick();
    endtask

    initial begin
        int wcnt;
        int dones;
        int acc;

        // Reset with requests asserted
        rst_n = 1'b0; mode = 1'b1; in_valid = 1'b1; start = 1'b1; out_ready = 1'b1;
        sel = 6'd3; salt = 4'hA; full_speed = 1'b0;
        tick();
        @(negedge clk);
        chk("reset in_ready", 32'(l2_ir), 32'd0);
        chk("reset busy", 32'(l2_busy), 32'd0);
        chk("reset done", 32'(l2_done), 32'd0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0; start = 1'b0; mode = 1'b0;
        repeat (2) tick();

        // Direct, back-to-back sel 5 then 15
        sel = 6'd5; in_valid = 1'b1;
        tick();
        sel = 6'd15;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("direct first valid", 32'(l2_ov), 32'd1);
        chk("direct first dout", 32'(l2_dout), 32'hA005);
        chk("direct first ch", 32'(l2_ch), 32'd5);
        @(negedge clk);
        chk("direct second dout", 32'(l2_dout), 32'hA00F);
        chk("direct second ch", 32'(l2_ch), 32'd15);
        @(negedge clk);
        chk("direct empty after", 32'(l2_ov), 32'd0);
        wait_idle();

        // Stall for three cycles, din changes after issue
        sel = 6'd5; in_valid = 1'b1;
        tick();
        sel = 6'd15;
        tick();
        sel = 6'd9; out_ready = 1'b0; salt = 4'hB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall dout", 32'(l2_dout), 32'hA005);
            chk("stall in_ready", 32'(l2_ir), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release dout 15", 32'(l2_dout), 32'hA00F);
        @(negedge clk);
        chk("release dout 9", 32'(l2_dout), 32'hB009);
        chk("release ch 9", 32'(l2_ch), 32'd9);
        @(negedge clk);
        chk("release empty", 32'(l2_ov), 32'd0);
        wait_idle();
        salt = 4'hA;

        // Scan at full speed
        full_speed = 1'b1; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wcnt = 0;
        @(negedge clk);
        while (!l2_ov && wcnt < 50) begin
            @(negedge clk);
            wcnt++;
        end
        chk("scan first beat latency", 32'(wcnt), 32'd2);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan valid %0d", k), 32'(l2_ov), 32'd1);
            chk($sformatf("scan ch %0d", k), 32'(l2_ch), 32'(k));
            chk($sformatf("scan dout %0d", k), 32'(l2_dout), 32'hA000 + 32'(k));
            @(negedge clk);
        end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (l2_done) dones++;
            @(negedge clk);
        end
        chk("scan done pulses", 32'(dones), 32'd1);
        wait_idle();
        full_speed = 1'b0;

        // Scan with random backpressure and spurious requests
        mode = 1'b1; start = 1'b1;
        tick();
        for (int i = 0; i < 150; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            sel       = 6'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            tick();
        end
        wait_idle();

        // Reset after seven beats of a scan
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        wcnt = 0;
        while (acc < 7 && wcnt < 100) begin
            @(negedge clk);
            if (l2_ov && out_ready) acc++;
            wcnt++;
        end
        chk("seven beats seen", 32'(acc), 32'd7);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(l2_busy), 32'd0);
        chk("abort valid", 32'(l2_ov), 32'd0);
        repeat (4) tick();
        full_speed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wcnt = 0;
        @(negedge clk);
        while (!l2_ov && wcnt < 50) begin
            @(negedge clk);
            wcnt++;
        end
        chk("restart first ch", 32'(l2_ch), 32'd0);
        chk("restart first dout", 32'(l2_dout), 32'hA000);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
